// File: rtl/texel_quad_fetch.sv
// rtl/texel_quad_fetch.sv - 2x2 texel footprint fetch for the bilinear filter stage
// Optional build macro: TEXFETCH_CLAMP_EN adds a clamp_mode input (1 = clamp-to-edge, 0 = wrap).
// Without it, addressing is wrap-only.

module texel_quad_fetch #(
    parameter int CHANNELS       = 4,
    parameter int CH_W           = 8,
    parameter int FRACT_BITS     = 8,
    parameter int COORD_INT_BITS = 12,
    parameter int TEX_W_LOG2     = 3,
    parameter int TEX_H_LOG2     = 3,
    parameter int ADDR_W         = 20
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [COORD_INT_BITS+FRACT_BITS-1:0] u,
    input  logic [COORD_INT_BITS+FRACT_BITS-1:0] v,
    input  logic [ADDR_W-1:0]                    base_addr,
`ifdef TEXFETCH_CLAMP_EN
    input  logic                                 clamp_mode,
`endif
    output logic                                 mem_req_valid,
    input  logic                                 mem_req_ready,
    output logic [ADDR_W-1:0]                    mem_addr,
    input  logic                                 mem_rvalid,
    input  logic [CHANNELS*CH_W-1:0]             mem_rdata,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [CHANNELS*CH_W-1:0]             texel00,
    output logic [CHANNELS*CH_W-1:0]             texel10,
    output logic [CHANNELS*CH_W-1:0]             texel01,
    output logic [CHANNELS*CH_W-1:0]             texel11,
    output logic [FRACT_BITS-1:0]                fx,
    output logic [FRACT_BITS-1:0]                fy
);

    localparam int CW = COORD_INT_BITS + FRACT_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_W-1:0]       base_q;
    logic [TEX_W_LOG2-1:0]   x0_q, x1_q;
    logic [TEX_H_LOG2-1:0]   y0_q, y1_q;
    logic [2:0]              issue_cnt;
    logic [2:0]              resp_cnt;

    logic [TEX_W_LOG2-1:0]   x0_n, x1_n;
    logic [TEX_H_LOG2-1:0]   y0_n, y1_n;
    logic [ADDR_W-1:0]       next_addr;

    // Integer bits above the texture size only matter for clamping; in wrap mode they are dropped.
    logic                    unused_coord_hi;
    assign unused_coord_hi = ^{u[CW-1:FRACT_BITS+TEX_W_LOG2], v[CW-1:FRACT_BITS+TEX_H_LOG2]};

    // Word address of texel (x,y): base + y*width + x, wrapping at the address width.
    function automatic logic [ADDR_W-1:0] texel_addr(
        input logic [ADDR_W-1:0]     base,
        input logic [TEX_W_LOG2-1:0] x,
        input logic [TEX_H_LOG2-1:0] y
    );
        logic [ADDR_W-1:0] off;
        off = '0;
        off[TEX_W_LOG2+TEX_H_LOG2-1:0] = {y, x};
        return base + off;
    endfunction

    // Split the incoming coordinate into the 2x2 neighbour indices.
    always_comb begin
        x0_n = u[FRACT_BITS +: TEX_W_LOG2];
        y0_n = v[FRACT_BITS +: TEX_H_LOG2];
        x1_n = x0_n + 1'b1;
        y1_n = y0_n + 1'b1;
`ifdef TEXFETCH_CLAMP_EN
        if (clamp_mode) begin
            if (|u[CW-1:FRACT_BITS+TEX_W_LOG2]) begin
                x0_n = '1;
            end
            if (|v[CW-1:FRACT_BITS+TEX_H_LOG2]) begin
                y0_n = '1;
            end
            x1_n = (x0_n == '1) ? x0_n : x0_n + 1'b1;
            y1_n = (y0_n == '1) ? y0_n : y0_n + 1'b1;
        end
`endif
    end

    // Address of the request that follows the one currently being handed over.
    always_comb begin
        next_addr = texel_addr(base_q, x1_q, y1_q);
        case (issue_cnt)
            3'd0:    next_addr = texel_addr(base_q, x1_q, y0_q);
            3'd1:    next_addr = texel_addr(base_q, x0_q, y1_q);
            default: next_addr = texel_addr(base_q, x1_q, y1_q);
        endcase
    end

    // Control FSM: accept a sample, issue four in-order reads, collect responses, present the quad.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            out_valid     <= 1'b0;
            texel00       <= '0;
            texel10       <= '0;
            texel01       <= '0;
            texel11       <= '0;
            fx            <= '0;
            fy            <= '0;
            base_q        <= '0;
            x0_q          <= '0;
            x1_q          <= '0;
            y0_q          <= '0;
            y1_q          <= '0;
            issue_cnt     <= '0;
            resp_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        base_q        <= base_addr;
                        fx            <= u[FRACT_BITS-1:0];
                        fy            <= v[FRACT_BITS-1:0];
                        x0_q          <= x0_n;
                        x1_q          <= x1_n;
                        y0_q          <= y0_n;
                        y1_q          <= y1_n;
                        mem_req_valid <= 1'b1;
                        mem_addr      <= texel_addr(base_addr, x0_n, y0_n);
                        issue_cnt     <= '0;
                        resp_cnt      <= '0;
                        in_ready      <= 1'b0;
                        state         <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_req_valid && mem_req_ready) begin
                        issue_cnt <= issue_cnt + 3'd1;
                        if (issue_cnt == 3'd3) begin
                            mem_req_valid <= 1'b0;
                        end else begin
                            mem_addr <= next_addr;
                        end
                    end
                    if (mem_rvalid && (resp_cnt < 3'd4)) begin
                        case (resp_cnt[1:0])
                            2'd0:    texel00 <= mem_rdata;
                            2'd1:    texel10 <= mem_rdata;
                            2'd2:    texel01 <= mem_rdata;
                            default: texel11 <= mem_rdata;
                        endcase
                        resp_cnt <= resp_cnt + 3'd1;
                        if (resp_cnt == 3'd3) begin
                            mem_req_valid <= 1'b0;
                            out_valid     <= 1'b1;
                            state         <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_texel_quad_fetch.sv
// tb/tb_texel_quad_fetch.sv - directed vector bench for texel_quad_fetch

module tb_texel_quad_fetch;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] u;
    logic [19:0] v;
    logic [19:0] base_addr;
    logic        clamp_mode;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [19:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] texel00, texel10, texel01, texel11;
    logic [7:0]  fx, fy;

    texel_quad_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .u             (u),
        .v             (v),
        .base_addr     (base_addr),
`ifdef TEXFETCH_CLAMP_EN
        .clamp_mode    (clamp_mode),
`endif
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .texel00       (texel00),
        .texel10       (texel10),
        .texel01       (texel01),
        .texel11       (texel11),
        .fx            (fx),
        .fy            (fy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0]      u;
        logic [19:0]      v;
        logic [19:0]      base;
        logic             cm;
        logic [3:0][19:0] a;
        logic [7:0]       fx;
        logic [7:0]       fy;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    vec_t        vecs[$];
    logic [19:0] addr_q[$];
    logic [19:0] stall_q[$];
    int          stall_idx = -1;
    int          stall_left = 0;
    int          spur = 0;
    int          req_n = 0;
    logic        hs_prev = 1'b0;
    logic [19:0] addr_prev = '0;

    function automatic vec_t mk(input logic [19:0] u_i, v_i, b_i, input logic cm_i,
                                input logic [19:0] a0, a1, a2, a3, input logic [7:0] fx_i, fy_i);
        vec_t t;
        t.u = u_i; t.v = v_i; t.base = b_i; t.cm = cm_i;
        t.a = {a3, a2, a1, a0};
        t.fx = fx_i; t.fy = fy_i;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Zero-wait memory: data = address, returned the cycle after each accepted request.
    initial begin
        mem_req_ready = 1'b1;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                hs_prev       = 1'b0;
                mem_rvalid    = 1'b0;
                mem_req_ready = 1'b1;
            end else begin
                mem_rvalid = hs_prev || (spur > 0);
                mem_rdata  = (spur > 0) ? 32'hDEAD_BEEF : {12'b0, addr_prev};
                if (spur > 0) spur--;
                if (mem_req_valid && (req_n == stall_idx) && (stall_left > 0)) begin
                    mem_req_ready = 1'b0;
                    stall_left--;
                    stall_q.push_back(mem_addr);
                end else begin
                    mem_req_ready = 1'b1;
                end
                hs_prev   = mem_req_valid && mem_req_ready;
                addr_prev = mem_addr;
                if (hs_prev) begin
                    addr_q.push_back(mem_addr);
                    req_n++;
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        check({tag, "_mem_req_valid"}, {31'b0, mem_req_valid}, 32'd0);
        check({tag, "_mem_addr"}, {12'b0, mem_addr}, 32'd0);
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_texel00"}, texel00, 32'd0);
        check({tag, "_texel10"}, texel10, 32'd0);
        check({tag, "_texel01"}, texel01, 32'd0);
        check({tag, "_texel11"}, texel11, 32'd0);
        check({tag, "_fx"}, {24'b0, fx}, 32'd0);
        check({tag, "_fy"}, {24'b0, fy}, 32'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of cycle 1.
    task automatic start_sample(input vec_t t);
        addr_q.delete();
        req_n = 0;
        check("accept_in_ready", {31'b0, in_ready}, 32'd1);
        u = t.u; v = t.v; base_addr = t.base; clamp_mode = t.cm;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_seen", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic check_quad(input string tag, input vec_t t);
        logic [19:0] a;
        check({tag, "_nreq"}, addr_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            a = (i < addr_q.size()) ? addr_q[i] : 20'hFFFFF;
            check($sformatf("%s_addr%0d", tag, i), {12'b0, a}, {12'b0, t.a[i]});
        end
        check({tag, "_texel00"}, texel00, {12'b0, t.a[0]});
        check({tag, "_texel10"}, texel10, {12'b0, t.a[1]});
        check({tag, "_texel01"}, texel01, {12'b0, t.a[2]});
        check({tag, "_texel11"}, texel11, {12'b0, t.a[3]});
        check({tag, "_fx"}, {24'b0, fx}, {24'b0, t.fx});
        check({tag, "_fy"}, {24'b0, fy}, {24'b0, t.fy});
    endtask

    // Hold out_ready low for n cycles, checking stability, then complete the handshake.
    task automatic handshake(input string tag, input int n);
        logic [143:0] snap;
        logic         stable;
        snap = {texel00, texel10, texel01, texel11, fx, fy};
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            stable = out_valid && !in_ready && (snap == {texel00, texel10, texel01, texel11, fx, fy});
            check($sformatf("%s_hold%0d", tag, i), {31'b0, stable}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_post_in_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        u = '0; v = '0; base_addr = '0; clamp_mode = 1'b0;

        vecs.push_back(mk(20'h00280, 20'h00340, 20'h00100, 1'b0, 20'h11A, 20'h11B, 20'h122, 20'h123, 8'h80, 8'h40));
        vecs.push_back(mk(20'h00700, 20'h00700, 20'h00100, 1'b0, 20'h13F, 20'h138, 20'h107, 20'h100, 8'h00, 8'h00));
        vecs.push_back(mk(20'h03000, 20'h0FF13, 20'hFFFF0, 1'b0, 20'h00028, 20'h00029, 20'hFFFF0, 20'hFFFF1, 8'h00, 8'h13));
        vecs.push_back(mk(20'h001FF, 20'h00000, 20'h00000, 1'b0, 20'h001, 20'h002, 20'h009, 20'h00A, 8'hFF, 8'h00));
`ifdef TEXFETCH_CLAMP_EN
        vecs.push_back(mk(20'h00700, 20'h00700, 20'h00100, 1'b1, 20'h13F, 20'h13F, 20'h13F, 20'h13F, 8'h00, 8'h00));
        vecs.push_back(mk(20'h03000, 20'h00340, 20'h00100, 1'b1, 20'h11F, 20'h11F, 20'h127, 20'h127, 8'h00, 8'h40));
`endif

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // Table-driven vectors with zero-wait memory.
        foreach (vecs[i]) begin
            start_sample(vecs[i]);
            wait_out(lat);
            check($sformatf("vec%0d_latency", i), lat, 32'd6);
            check_quad($sformatf("vec%0d", i), vecs[i]);
            handshake($sformatf("vec%0d", i), 0);
        end

        // Backpressure: 2nd request stalled 3 cycles, output stalled 5 cycles.
        stall_q.delete();
        stall_idx = 1; stall_left = 3;
        start_sample(vecs[0]);
        wait_out(lat);
        stall_idx = -1;
        check("bp_latency", lat, 32'd9);
        check("bp_nstall", stall_q.size(), 32'd3);
        foreach (stall_q[i]) check($sformatf("bp_stall_addr%0d", i), {12'b0, stall_q[i]}, 32'h11B);
        check_quad("bp", vecs[0]);
        handshake("bp", 5);

        // Back-to-back with in_valid held high, spurious rvalid in IDLE.
        addr_q.delete(); req_n = 0;
        u = vecs[0].u; v = vecs[0].v; base_addr = vecs[0].base; clamp_mode = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        u = vecs[1].u; v = vecs[1].v; base_addr = vecs[1].base;
        wait_out(lat);
        check("b2b_in_ready_busy", {31'b0, in_ready}, 32'd0);
        check_quad("b2b_a", vecs[0]);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_idle_in_ready", {31'b0, in_ready}, 32'd1);
        spur = 1;
        addr_q.delete(); req_n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        check("b2b_b_latency", lat, 32'd6);
        check_quad("b2b_b", vecs[1]);
        handshake("b2b_b", 0);

        // Reset in FETCH after two responses, then a clean sample.
        start_sample(vecs[0]);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        rst = 1'b0;
        @(negedge clk);
        check("midrst_no_reissue", {31'b0, mem_req_valid}, 32'd0);
        start_sample(vecs[2]);
        wait_out(lat);
        check("after_rst_latency", lat, 32'd6);
        check_quad("after_rst", vecs[2]);
        handshake("after_rst", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
